// File: rtl/simd_mem_loader.sv
// simd_mem_loader: streams a host word sequence into the simd_top instruction and data
// memories, runs the core until it finishes or times out, then streams the data memories back.
`default_nettype none

module simd_mem_loader #(
  parameter int IMEM_DEPTH    = 256,
  parameter int CP_DMEM_DEPTH = 256,
  parameter int PE_DMEM_DEPTH = 256,
  parameter int PE_NUM        = 4,
  parameter int PE_DW         = 16,
  parameter int RUN_TIMEOUT   = 1000000
) (
  input  logic                             rClk,
  input  logic                             rReset,
  input  logic                             iStart,
  input  logic                             iIn_Valid,
  input  logic [31:0]                      iIn_Data,
  output logic                             oIn_Ready,
  output logic                             oOut_Valid,
  output logic [31:0]                      oOut_Data,
  input  logic                             iOut_Ready,
  output logic                             oCore_Reset,
  input  logic                             iTask_Finished,
  output logic                             oIMEM_Valid,
  output logic                             oIMEM_Write_Enable,
  output logic [$clog2(IMEM_DEPTH)-1:0]    oIMEM_Address,
  output logic [63:0]                      oIMEM_Write_Data,
  output logic                             oCP_DMEM_Valid,
  output logic                             oCP_DMEM_Write_Enable,
  output logic [$clog2(CP_DMEM_DEPTH)+1:0] oCP_DMEM_Address,
  output logic [31:0]                      oCP_DMEM_Write_Data,
  input  logic [31:0]                      iCP_DMEM_Read_Data,
  output logic                             oPE_DMEM_Valid,
  output logic                             oPE_DMEM_Write_Enable,
  output logic [$clog2(PE_DMEM_DEPTH)+1:0] oPE_DMEM_Address,
  output logic [PE_NUM*PE_DW-1:0]          oPE_DMEM_Write_Data,
  input  logic [PE_NUM*PE_DW-1:0]          iPE_DMEM_Read_Data,
  output logic                             oBusy,
  output logic                             oDone,
  output logic                             oTimeout,
  output logic [31:0]                      oRun_Cycles
);

  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int CA = $clog2(CP_DMEM_DEPTH);
  localparam int PA = $clog2(PE_DMEM_DEPTH);
  localparam int LW = (PE_NUM > 2) ? $clog2(PE_NUM) : 1;
  localparam int PW = PE_NUM * PE_DW;

  localparam logic [31:0]   IMEM_LAST     = 32'(IMEM_DEPTH - 1);
  localparam logic [31:0]   CP_LAST       = 32'(CP_DMEM_DEPTH - 1);
  localparam logic [31:0]   PE_LAST       = 32'(PE_DMEM_DEPTH - 1);
  localparam logic [31:0]   CP_COUNT      = 32'(CP_DMEM_DEPTH);
  localparam logic [31:0]   PE_COUNT      = 32'(PE_DMEM_DEPTH);
  localparam logic [31:0]   PE_BEATS_LAST = 32'(PE_DMEM_DEPTH * PE_NUM - 1);
  localparam logic [31:0]   TIMEOUT_CYC   = 32'(RUN_TIMEOUT);
  localparam logic [LW-1:0] LANE_LAST     = LW'(PE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE, LD_IMEM, LD_CPD, LD_PED, RUN, DUMP_CP, DUMP_PE
  } state_t;

  state_t          state, state_next;
  logic [31:0]     addr;
  logic [31:0]     emit;
  logic [LW-1:0]   lane;
  logic [31:0]     cp_hold;
  logic [PW-1:0]   pe_word;
  logic [PW-1:0]   pack_word;
  logic [31:0]     lane_word;
  logic [31:0]     run_next;
  logic            rd_issue, rd_s1, rd_s2, buf_full;
  logic            in_fire, out_fire;

  assign oIn_Ready   = (state == LD_IMEM) || (state == LD_CPD) || (state == LD_PED);
  assign oBusy       = (state != IDLE);
  assign oCore_Reset = (state != RUN);
  assign in_fire     = iIn_Valid && oIn_Ready;
  assign out_fire    = oOut_Valid && iOut_Ready;
  assign run_next    = (oRun_Cycles == '1) ? oRun_Cycles : oRun_Cycles + 32'd1;

  always_ff @(posedge rClk) begin
    if (!rReset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_issue   = 1'b0;
    pack_word  = pe_word;
    pack_word[int'(lane)*PE_DW +: PE_DW] = iIn_Data[PE_DW-1:0];
    lane_word  = 32'(pe_word[int'(lane)*PE_DW +: PE_DW]);
    case (state)
      IDLE:    if (iStart) state_next = LD_IMEM;
      LD_IMEM: if (in_fire && lane != '0 && addr == IMEM_LAST) state_next = LD_CPD;
      LD_CPD:  if (in_fire && addr == CP_LAST) state_next = LD_PED;
      LD_PED:  if (in_fire && lane == LANE_LAST && addr == PE_LAST) state_next = RUN;
      RUN:     if (iTask_Finished || run_next >= TIMEOUT_CYC) state_next = DUMP_CP;
      DUMP_CP: begin
        // Single read in flight, and only when the output slot is free by the time it returns.
        rd_issue = (addr < CP_COUNT) && !rd_s1 && !rd_s2 && (!oOut_Valid || out_fire);
        if (out_fire && emit == CP_LAST) state_next = DUMP_PE;
      end
      DUMP_PE: begin
        rd_issue = (addr < PE_COUNT) && !rd_s1 && !rd_s2 && !buf_full && !oOut_Valid;
        if (out_fire && emit == PE_BEATS_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rClk) begin
    if (!rReset) begin
      addr <= '0; emit <= '0; lane <= '0; cp_hold <= '0; pe_word <= '0;
      rd_s1 <= 1'b0; rd_s2 <= 1'b0; buf_full <= 1'b0;
      oOut_Valid <= 1'b0; oOut_Data <= '0;
      oIMEM_Valid <= 1'b0; oIMEM_Write_Enable <= 1'b0; oIMEM_Address <= '0; oIMEM_Write_Data <= '0;
      oCP_DMEM_Valid <= 1'b0; oCP_DMEM_Write_Enable <= 1'b0; oCP_DMEM_Address <= '0;
      oCP_DMEM_Write_Data <= '0;
      oPE_DMEM_Valid <= 1'b0; oPE_DMEM_Write_Enable <= 1'b0; oPE_DMEM_Address <= '0;
      oPE_DMEM_Write_Data <= '0;
      oDone <= 1'b0; oTimeout <= 1'b0; oRun_Cycles <= '0;
    end else begin
      oIMEM_Valid <= 1'b0; oIMEM_Write_Enable <= 1'b0;
      oCP_DMEM_Valid <= 1'b0; oCP_DMEM_Write_Enable <= 1'b0;
      oPE_DMEM_Valid <= 1'b0; oPE_DMEM_Write_Enable <= 1'b0;
      oDone <= 1'b0;
      rd_s1 <= rd_issue;
      rd_s2 <= rd_s1;
      case (state)
        IDLE: if (iStart) begin
          addr <= '0; emit <= '0; lane <= '0;
          oRun_Cycles <= '0; oTimeout <= 1'b0;
        end
        LD_IMEM: if (in_fire) begin
          if (lane == '0) begin
            cp_hold <= iIn_Data;
            lane    <= LW'(1);
          end else begin
            oIMEM_Valid <= 1'b1; oIMEM_Write_Enable <= 1'b1;
            oIMEM_Address    <= addr[IA-1:0];
            oIMEM_Write_Data <= {iIn_Data, cp_hold};
            lane <= '0;
            addr <= (addr == IMEM_LAST) ? 32'd0 : addr + 32'd1;
          end
        end
        LD_CPD: if (in_fire) begin
          oCP_DMEM_Valid <= 1'b1; oCP_DMEM_Write_Enable <= 1'b1;
          oCP_DMEM_Address    <= {addr[CA-1:0], 2'b00};
          oCP_DMEM_Write_Data <= iIn_Data;
          addr <= (addr == CP_LAST) ? 32'd0 : addr + 32'd1;
        end
        LD_PED: if (in_fire) begin
          pe_word <= pack_word;
          if (lane == LANE_LAST) begin
            oPE_DMEM_Valid <= 1'b1; oPE_DMEM_Write_Enable <= 1'b1;
            oPE_DMEM_Address    <= {addr[PA-1:0], 2'b00};
            oPE_DMEM_Write_Data <= pack_word;
            lane <= '0;
            addr <= (addr == PE_LAST) ? 32'd0 : addr + 32'd1;
          end else begin
            lane <= lane + LW'(1);
          end
        end
        RUN: begin
          oRun_Cycles <= run_next;
          if (!iTask_Finished && run_next >= TIMEOUT_CYC) oTimeout <= 1'b1;
        end
        DUMP_CP: begin
          if (rd_issue) begin
            oCP_DMEM_Valid   <= 1'b1;
            oCP_DMEM_Address <= {addr[CA-1:0], 2'b00};
            addr <= addr + 32'd1;
          end
          if (rd_s2) begin
            oOut_Valid <= 1'b1;
            oOut_Data  <= iCP_DMEM_Read_Data;
          end else if (out_fire) begin
            oOut_Valid <= 1'b0;
          end
          if (out_fire) begin
            emit <= emit + 32'd1;
            if (emit == CP_LAST) begin
              emit <= '0;
              addr <= '0;
            end
          end
        end
        DUMP_PE: begin
          if (rd_issue) begin
            oPE_DMEM_Valid   <= 1'b1;
            oPE_DMEM_Address <= {addr[PA-1:0], 2'b00};
            addr <= addr + 32'd1;
          end
          // Read word parks in pe_word; lanes are handed to the output slot one by one.
          if (rd_s2) begin
            pe_word  <= iPE_DMEM_Read_Data;
            buf_full <= 1'b1;
            lane     <= '0;
          end else if (buf_full && (!oOut_Valid || out_fire)) begin
            oOut_Valid <= 1'b1;
            oOut_Data  <= lane_word;
            if (lane == LANE_LAST) begin
              lane     <= '0;
              buf_full <= 1'b0;
            end else begin
              lane <= lane + LW'(1);
            end
          end else if (out_fire) begin
            oOut_Valid <= 1'b0;
          end
          if (out_fire) begin
            emit <= emit + 32'd1;
            if (emit == PE_BEATS_LAST) begin
              oDone <= 1'b1;
              emit  <= '0;
              addr  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_simd_mem_loader.sv
// Directed bench for simd_mem_loader with small memories and host-side memory models.
`default_nettype none

module tb_simd_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        core_reset;
  logic        finished = 1'b0;
  logic        imem_valid, imem_we;
  logic [1:0]  imem_addr;
  logic [63:0] imem_wdata;
  logic        cp_valid, cp_we;
  logic [3:0]  cp_addr;
  logic [31:0] cp_wdata;
  logic [31:0] cp_rdata = '0;
  logic        pe_valid, pe_we;
  logic [3:0]  pe_addr;
  logic [63:0] pe_wdata;
  logic [63:0] pe_rdata = '0;
  logic        busy, done, timeout;
  logic [31:0] run_cycles;

  always #5 clk = ~clk;

  simd_mem_loader #(
    .IMEM_DEPTH(4), .CP_DMEM_DEPTH(4), .PE_DMEM_DEPTH(4),
    .PE_NUM(4), .PE_DW(16), .RUN_TIMEOUT(60)
  ) dut (
    .rClk(clk), .rReset(rst_n), .iStart(start),
    .iIn_Valid(in_valid), .iIn_Data(in_data), .oIn_Ready(in_ready),
    .oOut_Valid(out_valid), .oOut_Data(out_data), .iOut_Ready(out_ready),
    .oCore_Reset(core_reset), .iTask_Finished(finished),
    .oIMEM_Valid(imem_valid), .oIMEM_Write_Enable(imem_we),
    .oIMEM_Address(imem_addr), .oIMEM_Write_Data(imem_wdata),
    .oCP_DMEM_Valid(cp_valid), .oCP_DMEM_Write_Enable(cp_we),
    .oCP_DMEM_Address(cp_addr), .oCP_DMEM_Write_Data(cp_wdata),
    .iCP_DMEM_Read_Data(cp_rdata),
    .oPE_DMEM_Valid(pe_valid), .oPE_DMEM_Write_Enable(pe_we),
    .oPE_DMEM_Address(pe_addr), .oPE_DMEM_Write_Data(pe_wdata),
    .iPE_DMEM_Read_Data(pe_rdata),
    .oBusy(busy), .oDone(done), .oTimeout(timeout), .oRun_Cycles(run_cycles)
  );

  typedef struct {
    logic [1:0]  mem;   // 0 IMEM, 1 CP DMEM, 2 PE DMEM
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         wlog[$];
  wr_t         wr_tab[12];
  logic [31:0] exp_dump[20];
  logic [31:0] cp_mem[4];
  logic [63:0] pe_mem[4];
  int          beat_cnt = 0;
  int          done_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  // Synchronous-read memory models plus a log of every write strobe.
  always @(posedge clk) begin
    if (imem_valid && imem_we) wlog.push_back(wr_t'{2'd0, 64'(imem_addr), imem_wdata});
    if (cp_valid && cp_we)     wlog.push_back(wr_t'{2'd1, 64'(cp_addr), 64'(cp_wdata)});
    if (pe_valid && pe_we)     wlog.push_back(wr_t'{2'd2, 64'(pe_addr), pe_wdata});
    if (cp_valid) begin
      if (cp_we) cp_mem[cp_addr[3:2]] <= cp_wdata;
      else       cp_rdata <= cp_mem[cp_addr[3:2]];
    end
    if (pe_valid) begin
      if (pe_we) pe_mem[pe_addr[3:2]] <= pe_wdata;
      else       pe_rdata <= pe_mem[pe_addr[3:2]];
    end
    if (rst_n && in_valid && in_ready) beat_cnt <= beat_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_session();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic load(input bit bubbles, input int nbeats);
    int n = 0;
    int cyc = 0;
    while (n < nbeats && cyc < 400) begin
      in_valid = bubbles ? (cyc % 2 == 0) : 1'b1;
      in_data  = 32'h100 + 32'(n);
      #1;
      if (in_valid && in_ready) n++;
      cyc++;
      @(negedge clk);
    end
    check("load_beats_sent", 64'(n), 64'(nbeats));
  endtask

  task automatic check_writes(input int base, input string tag);
    check({tag, "_nwrites"}, 64'(wlog.size() - base), 64'd12);
    for (int r = 0; r < 12; r++) begin
      if (base + r < wlog.size()) begin
        check($sformatf("%s_wr%0d_mem", tag, r),  64'(wlog[base+r].mem), 64'(wr_tab[r].mem));
        check($sformatf("%s_wr%0d_addr", tag, r), wlog[base+r].addr, wr_tab[r].addr);
        check($sformatf("%s_wr%0d_data", tag, r), wlog[base+r].data, wr_tab[r].data);
      end
    end
  endtask

  task automatic wait_run();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!core_reset) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("run_entered", 64'(ok), 64'd1);
  endtask

  // Assumes the caller sits at the first RUN cycle; finish is raised in RUN cycle ncyc.
  task automatic run_finish(input int ncyc, input string tag);
    check({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
    repeat (ncyc - 1) @(negedge clk);
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    check({tag, "_core_reset_dump"}, 64'(core_reset), 64'd1);
    check({tag, "_run_cycles"}, 64'(run_cycles), 64'(ncyc));
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
  endtask

  task automatic dump_collect(input bit rnd, input string tag);
    int          k = 0;
    int          cyc = 0;
    bit          stall = 1'b0;
    logic [31:0] held = '0;
    int          done_base = done_cnt;
    while (k < 20 && cyc < 2000) begin
      if (stall) begin
        check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_stall_data"}, 64'(out_data), 64'(held));
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        check($sformatf("%s_word%0d", tag, k), 64'(out_data), 64'(exp_dump[k]));
        k++;
        stall = 1'b0;
      end else begin
        stall = out_valid;
        held  = out_data;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check({tag, "_nwords"}, 64'(k), 64'd20);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_out_valid_idle"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wbase;
    int bbase;
    int rc;
    int dbase;

    wr_tab[0]  = '{2'd0, 64'h0, 64'h00000101_00000100};
    wr_tab[1]  = '{2'd0, 64'h1, 64'h00000103_00000102};
    wr_tab[2]  = '{2'd0, 64'h2, 64'h00000105_00000104};
    wr_tab[3]  = '{2'd0, 64'h3, 64'h00000107_00000106};
    wr_tab[4]  = '{2'd1, 64'h0, 64'h108};
    wr_tab[5]  = '{2'd1, 64'h4, 64'h109};
    wr_tab[6]  = '{2'd1, 64'h8, 64'h10A};
    wr_tab[7]  = '{2'd1, 64'hC, 64'h10B};
    wr_tab[8]  = '{2'd2, 64'h0, 64'h010F_010E_010D_010C};
    wr_tab[9]  = '{2'd2, 64'h4, 64'h0113_0112_0111_0110};
    wr_tab[10] = '{2'd2, 64'h8, 64'h0117_0116_0115_0114};
    wr_tab[11] = '{2'd2, 64'hC, 64'h011B_011A_0119_0118};
    // CP words then PE lanes happen to form one contiguous run of input values.
    for (int i = 0; i < 20; i++) exp_dump[i] = 32'h108 + 32'(i);

    // Reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_strobes", 64'({imem_valid, imem_we, cp_valid, cp_we, pe_valid, pe_we}), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_pe_wdata", pe_wdata, 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_run_cycles", 64'(run_cycles), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // Session A: streaming load, finish after 50 RUN cycles, random backpressure dump
    wbase = wlog.size();
    bbase = beat_cnt;
    start_session();
    check("a_busy", 64'(busy), 64'd1);
    check("a_in_ready_load", 64'(in_ready), 64'd1);
    load(1'b0, 28);
    wait_run();
    run_finish(50, "a");
    check("a_beats_accepted", 64'(beat_cnt - bbase), 64'd28);
    in_valid = 1'b0;
    check_writes(wbase, "a");
    dump_collect(1'b1, "a");

    // Session B: bubbled load, no finish -> timeout
    wbase = wlog.size();
    start_session();
    load(1'b1, 28);
    in_valid = 1'b0;
    wait_run();
    rc = 0;
    while (!core_reset && rc < 200) begin
      rc++;
      @(negedge clk);
    end
    check("b_run_len", 64'(rc), 64'd60);
    check("b_timeout", 64'(timeout), 64'd1);
    check("b_run_cycles", 64'(run_cycles), 64'd60);
    check_writes(wbase, "b");
    dump_collect(1'b0, "b");
    check("b_timeout_sticky", 64'(timeout), 64'd1);

    // Session C: finish on the exact timeout cycle counts as finished
    start_session();
    check("c_timeout_cleared", 64'(timeout), 64'd0);
    check("c_run_cycles_cleared", 64'(run_cycles), 64'd0);
    load(1'b0, 28);
    in_valid = 1'b0;
    wait_run();
    run_finish(60, "c");
    dump_collect(1'b1, "c");

    // Session D: reset mid-load keeps completed writes, drops the partial entry, no done
    wbase = wlog.size();
    dbase = done_cnt;
    start_session();
    load(1'b0, 3);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("d_busy", 64'(busy), 64'd0);
    check("d_core_reset", 64'(core_reset), 64'd1);
    check("d_in_ready", 64'(in_ready), 64'd0);
    repeat (4) @(negedge clk);
    check("d_writes_kept", 64'(wlog.size() - wbase), 64'd1);
    check("d_no_done", 64'(done_cnt - dbase), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
